sd_crc_lanes: RTL and testbench

Parametrised multi-lane CRC engine for the SD host: one CRC LFSR per data line, configurable polynomial and width. It serves both the CMD line (CRC7, 1 lane) and the DAT bus (CRC16, 1/4/8 lanes). It accumulates serial bits, then serially emits the CRC on all lanes in parallel, and optionally checks the received-CRC residue. It sits between the cmd/data serialisers and the SD pins.

---
 rtl/sd_crc_pkg.sv | 15 +
 rtl/sd_crc_lane.sv | 45 ++++
 rtl/sd_crc_lanes.sv | 109 ++++++++++
 tb/tb_sd_crc_lanes.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sd_crc_pkg.sv
// Shared constants and FSM state type for the SD CRC lane engine.
// CMD line uses CRC7, DAT lines use CRC16 (CCITT, no reflection, zero seed).
package sd_crc_pkg;

  localparam int         CRC7_W     = 7;
  localparam logic [6:0] CRC7_POLY  = 7'h09;
  localparam int         CRC16_W    = 16;
  localparam logic [15:0] CRC16_POLY = 16'h1021;

  typedef enum logic {
    ACCUM = 1'b0,
    FLUSH = 1'b1
  } crc_state_e;

endpackage

// File: rtl/sd_crc_lane.sv
// One serial CRC LFSR: accumulate a bit, shift the remainder out, or clear.
// Controls are mutually exclusive by construction in the parent.
module sd_crc_lane
  import sd_crc_pkg::*;
#(
  parameter int               CRC_W = CRC7_W,
  parameter logic [CRC_W-1:0] POLY  = CRC7_POLY
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             clear_i,
  input  logic             accum_i,
  input  logic             shift_i,
  input  logic             din_i,
  output logic [CRC_W-1:0] crc_o
);

  logic [CRC_W-1:0] crc_q;
  logic [CRC_W-1:0] crc_d;
  logic             inv;

  assign inv = din_i ^ crc_q[CRC_W-1];

  always_comb begin
    crc_d = crc_q;
    if (clear_i) begin
      crc_d = '0;
    end else if (shift_i) begin
      crc_d = {crc_q[CRC_W-2:0], 1'b0};
    end else if (accum_i) begin
      crc_d = {crc_q[CRC_W-2:0], 1'b0} ^ (inv ? POLY : '0);
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      crc_q <= '0;
    end else begin
      crc_q <= crc_d;
    end
  end

  assign crc_o = crc_q;

endmodule

// File: rtl/sd_crc_lanes.sv
// Multi-lane SD CRC engine: per-lane LFSRs, serial MSB-first emission.
// Define SD_CRC_CHECK_EN to build the sticky residue checker (crc_err).
module sd_crc_lanes
  import sd_crc_pkg::*;
#(
  parameter int               CRC_W = CRC7_W,
  parameter logic [CRC_W-1:0] POLY  = CRC7_POLY,
  parameter int               LANES = 1
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   clear,
  input  logic                   in_valid,
  input  logic [LANES-1:0]       din,
  input  logic                   flush,
  output logic [LANES-1:0]       crc_out,
  output logic                   crc_out_valid,
  output logic                   flush_done,
  output logic [LANES*CRC_W-1:0] crc_all,
  input  logic                   check,
  output logic                   crc_err
);

  localparam int               CNT_W = $clog2(CRC_W);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(CRC_W - 1);

  crc_state_e       state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             in_flush;
  logic             accum;
  logic             shift;

  assign in_flush = (state_q == FLUSH);
  assign accum    = ~clear & ~in_flush & in_valid;
  assign shift    = ~clear & in_flush;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    sd_crc_lane #(
      .CRC_W (CRC_W),
      .POLY  (POLY)
    ) u_lane (
      .CLK     (CLK),
      .RST     (RST),
      .clear_i (clear),
      .accum_i (accum),
      .shift_i (shift),
      .din_i   (din[i]),
      .crc_o   (crc_all[i*CRC_W +: CRC_W])
    );
    assign crc_out[i] = in_flush & crc_all[i*CRC_W + CRC_W - 1];
  end

  assign crc_out_valid = in_flush;
  assign flush_done    = in_flush && (cnt_q == LAST);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= ACCUM;
      cnt_q   <= '0;
    end else if (clear) begin
      state_q <= ACCUM;
      cnt_q   <= '0;
    end else begin
      unique case (state_q)
        ACCUM: begin
          if (flush) begin
            state_q <= FLUSH;
            cnt_q   <= '0;
          end
        end
        FLUSH: begin
          if (cnt_q == LAST) begin
            state_q <= ACCUM;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: begin
          state_q <= ACCUM;
          cnt_q   <= '0;
        end
      endcase
    end
  end

`ifdef SD_CRC_CHECK_EN
  logic err_q;

  // A clean frame (data followed by its CRC) leaves every lane at zero.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      err_q <= 1'b0;
    end else if (clear) begin
      err_q <= 1'b0;
    end else if (!in_flush && check && (|crc_all)) begin
      err_q <= 1'b1;
    end
  end

  assign crc_err = err_q;
`else
  logic unused_check;

  assign unused_check = check;
  assign crc_err      = 1'b0;
`endif

endmodule

// File: tb/tb_sd_crc_lanes.sv
// Bench for sd_crc_lanes: CRC7 x1 directed checks, CRC16 x4 random run
// against a polynomial-remainder model compared every cycle.
module tb_sd_crc_lanes;
  import sd_crc_pkg::*;

  localparam int          W  = CRC16_W;
  localparam int          L  = 4;
  localparam logic [15:0] P  = CRC16_POLY;
  localparam int          BW = CRC7_W;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  logic           a_clear = 0, a_in_valid = 0, a_flush = 0, a_check = 0;
  logic [L-1:0]   a_din = '0;
  logic [L-1:0]   a_out;
  logic           a_valid, a_done, a_err;
  logic [L*W-1:0] a_all;

  logic            b_clear = 0, b_in_valid = 0, b_flush = 0, b_check = 0;
  logic [0:0]      b_din = '0;
  logic [0:0]      b_out;
  logic            b_valid, b_done, b_err;
  logic [BW-1:0]   b_all;

  sd_crc_lanes #(.CRC_W(W), .POLY(P), .LANES(L)) u_a (
    .CLK(CLK), .RST(RST), .clear(a_clear), .in_valid(a_in_valid),
    .din(a_din), .flush(a_flush), .crc_out(a_out),
    .crc_out_valid(a_valid), .flush_done(a_done), .crc_all(a_all),
    .check(a_check), .crc_err(a_err)
  );

  sd_crc_lanes #(.CRC_W(BW), .POLY(CRC7_POLY), .LANES(1)) u_b (
    .CLK(CLK), .RST(RST), .clear(b_clear), .in_valid(b_in_valid),
    .din(b_din), .flush(b_flush), .crc_out(b_out),
    .crc_out_valid(b_valid), .flush_done(b_done), .crc_all(b_all),
    .check(b_check), .crc_err(b_err)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Remainder update R' = (R*x + b*x^w) mod G(x)
  function automatic logic [15:0] app(input logic [15:0] r, input logic b,
                                      input int w, input logic [15:0] p);
    logic [16:0] t;
    logic [16:0] g;
    g    = (17'd1 << w) | {1'b0, p};
    t    = {1'b0, r} << 1;
    t[w] = t[w] ^ b;
    if (t[w]) t = t ^ g;
    return t[15:0];
  endfunction

  function automatic logic [L*W-1:0] step_all(input logic [L*W-1:0] r,
                                              input logic [L-1:0] d);
    logic [L*W-1:0] s;
    for (int l = 0; l < L; l++) s[l*W +: W] = app(r[l*W +: W], d[l], W, P);
    return s;
  endfunction

  logic [L*W-1:0] m_rem  = '0;
  logic [L*W-1:0] m_emit = '0;
  logic           m_fl   = 1'b0;
  int             m_idx  = 0;
  logic           m_err  = 1'b0;

  always @(posedge CLK or posedge RST) begin
    if (RST || a_clear) begin
      m_rem <= '0; m_emit <= '0; m_fl <= 1'b0; m_idx <= 0; m_err <= 1'b0;
    end else if (m_fl) begin
      if (m_idx == W - 1) begin
        m_fl <= 1'b0; m_idx <= 0; m_rem <= '0;
      end else begin
        m_idx <= m_idx + 1;
      end
    end else begin
      if (a_in_valid) m_rem <= step_all(m_rem, a_din);
      if (a_flush) begin
        m_emit <= a_in_valid ? step_all(m_rem, a_din) : m_rem;
        m_fl   <= 1'b1;
        m_idx  <= 0;
      end
`ifdef SD_CRC_CHECK_EN
      if (a_check && (|m_rem)) m_err <= 1'b1;
`endif
    end
  end

  bit cmp_en = 0;

  always @(negedge CLK) begin : cmp
    logic [L*W-1:0] e_all;
    logic [L-1:0]   e_out;
    if (cmp_en && !RST) begin
      for (int l = 0; l < L; l++) begin
        e_all[l*W +: W] = m_fl ? (m_emit[l*W +: W] << m_idx) : m_rem[l*W +: W];
        e_out[l] = m_fl ? m_emit[l*W + W - 1 - m_idx] : 1'b0;
      end
      chk("a_crc_all", 64'(a_all), 64'(e_all));
      chk("a_crc_out", 64'(a_out), 64'(e_out));
      chk("a_valid", 64'(a_valid), 64'(m_fl));
      chk("a_done", 64'(a_done), 64'(m_fl && m_idx == W - 1));
      chk("a_err", 64'(a_err), 64'(m_err));
    end
  end

  task automatic b_feed(input logic [63:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      @(posedge CLK); #1;
      b_in_valid = 1'b1;
      b_din      = v[i];
    end
    @(posedge CLK); #1;
    b_in_valid = 1'b0;
  endtask

  task automatic b_pulse_clear();
    @(posedge CLK); #1 b_clear = 1'b1;
    @(posedge CLK); #1 b_clear = 1'b0;
  endtask

  task automatic b_pulse_check();
    @(posedge CLK); #1 b_check = 1'b1;
    @(posedge CLK); #1 b_check = 1'b0;
  endtask

  task automatic b_flush_exp(input logic [6:0] e);
    @(posedge CLK); #1 b_flush = 1'b1;
    @(posedge CLK); #1 b_flush = 1'b0;
    for (int k = 0; k < BW; k++) begin
      @(negedge CLK);
      chk("b_out_bit", 64'(b_out), 64'(e[BW-1-k]));
      chk("b_out_valid", 64'(b_valid), 64'd1);
      chk("b_done", 64'(b_done), 64'(k == BW - 1));
    end
    @(negedge CLK);
    chk("b_valid_after", 64'(b_valid), 64'd0);
    chk("b_all_after", 64'(b_all), 64'd0);
  endtask

  task automatic a_cycle(input logic v, input logic [L-1:0] d,
                         input logic f);
    @(posedge CLK); #1;
    a_in_valid = v; a_din = d; a_flush = f;
    a_clear = 1'b0; a_check = 1'b0;
  endtask

  task automatic a_idle();
    @(posedge CLK); #1;
    a_in_valid = 0; a_flush = 0; a_clear = 0; a_check = 0;
  endtask

  logic [15:0]    r;
  logic [63:0]    cmd0;
  logic [L*W-1:0] snap;
  logic           exp_err;

  initial begin
    cmd0 = 64'h40_0000_0000;
`ifdef SD_CRC_CHECK_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif

    repeat (3) @(posedge CLK);
    #1 RST = 1'b0;
    cmp_en = 1;
    @(negedge CLK);
    chk("rst_b_all", 64'(b_all), 64'd0);
    chk("rst_b_valid", 64'(b_valid), 64'd0);
    chk("rst_b_out", 64'(b_out), 64'd0);
    chk("rst_b_done", 64'(b_done), 64'd0);
    chk("rst_b_err", 64'(b_err), 64'd0);
    chk("rst_a_all", 64'(a_all), 64'd0);

    r = '0;
    for (int i = 0; i < 4096; i++) r = app(r, 1'b1, W, P);
    chk("model_ff512", 64'(r), 64'h7FA1);
    r = '0;
    for (int i = 39; i >= 0; i--) r = app(r, cmd0[i], BW, 16'(CRC7_POLY));
    chk("model_cmd0", 64'(r), 64'h4A);

    b_feed(cmd0, 40);
    @(negedge CLK);
    chk("b_cmd0_crc", 64'(b_all), 64'h4A);
    b_flush_exp(7'h4A);

    b_feed(64'h48_0000_01AA, 40);
    @(negedge CLK);
    chk("b_cmd8_crc", 64'(b_all), 64'h43);
    b_pulse_clear();
    @(negedge CLK);
    chk("b_clear", 64'(b_all), 64'd0);

    b_feed({cmd0[56:0], 7'h4A}, 47);
    b_pulse_check();
    @(negedge CLK);
    chk("b_err_good", 64'(b_err), 64'd0);
    b_feed({cmd0[56:0], 7'h4B}, 47);
    b_pulse_check();
    @(negedge CLK);
    chk("b_err_bad", 64'(b_err), 64'(exp_err));
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    chk("b_err_sticky", 64'(b_err), 64'(exp_err));
    b_pulse_clear();
    @(negedge CLK);
    chk("b_err_clr", 64'(b_err), 64'd0);

    for (int i = 0; i < 4096; i++) a_cycle(1'b1, '1, 1'b0);
    a_idle();
    @(negedge CLK);
    for (int l = 0; l < L; l++)
      chk("a_ff512_lane", 64'(a_all[l*W +: W]), 64'h7FA1);
    a_cycle(1'b0, '0, 1'b1);
    a_idle();
    repeat (W) @(posedge CLK);
    @(negedge CLK);
    chk("a_after_flush", 64'(a_all), 64'd0);

    for (int i = 0; i < 30; i++) a_cycle(1'b1, L'($urandom), 1'b0);
    a_cycle(1'b1, L'($urandom), 1'b1);
    for (int i = 0; i < W + 2; i++)
      a_cycle(1'b1, L'($urandom), 1'($urandom));
    a_idle();

    @(posedge CLK); #1 a_clear = 1'b1;
    @(posedge CLK); #1 a_clear = 1'b0;
    for (int i = 0; i < 20; i++) a_cycle(1'b1, L'($urandom), 1'b0);
    a_idle();
    snap = m_rem;
    for (int k = W - 1; k >= 0; k--) begin
      logic [L-1:0] d;
      for (int l = 0; l < L; l++) d[l] = snap[l*W + k];
      a_cycle(1'b1, d, 1'b0);
    end
    a_idle();
    @(posedge CLK); #1 a_check = 1'b1;
    @(posedge CLK); #1 a_check = 1'b0;
    @(negedge CLK);
    chk("a_residue_zero", 64'(a_all), 64'd0);
    chk("a_err_good", 64'(a_err), 64'd0);

    for (int i = 0; i < 3000; i++) begin
      @(posedge CLK); #1;
      a_in_valid = ($urandom % 10) < 7;
      a_din      = L'($urandom);
      a_flush    = ($urandom % 40) == 0;
      a_clear    = ($urandom % 300) == 0;
      a_check    = ($urandom % 20) == 0;
    end
    a_idle();

    @(posedge CLK); #1 a_clear = 1'b1;
    @(posedge CLK); #1 a_clear = 1'b0;
    for (int i = 0; i < 25; i++) a_cycle(1'b1, L'($urandom), 1'b0);
    a_cycle(1'b0, '0, 1'b1);
    a_idle();
    repeat (5) @(posedge CLK);
    #2 RST = 1'b1;
    #1;
    chk("rst_mid_valid", 64'(a_valid), 64'd0);
    chk("rst_mid_out", 64'(a_out), 64'd0);
    chk("rst_mid_all", 64'(a_all), 64'd0);
    chk("rst_mid_done", 64'(a_done), 64'd0);
    @(negedge CLK);
    RST = 1'b0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
